// File: rtl/ps2_key_sequencer.sv
// PS/2 scancode sequencer: prefix/modifier tracking, converter drive, key FIFO.
// Optional caps-lock handling is enabled by defining PS2_CAPSLOCK_EN.
module ps2_key_sequencer #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            sc_valid,
  input  logic [7:0]                      sc_data,
  output logic                            sc_ready,
  output logic [7:0]                      conv_sc,
  output logic                            conv_shift,
  output logic                            conv_ctrl,
  output logic                            conv_alt,
  output logic                            conv_extend,
  input  logic [7:0]                      conv_ascii,
  output logic                            key_valid,
  output logic [7:0]                      key_ascii,
  input  logic                            key_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] key_count,
  output logic                            overflow,
  output logic                            caps_lock
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);

  // modifier bit positions
  localparam int LSH = 0;
  localparam int RSH = 1;
  localparam int LCT = 2;
  localparam int RCT = 3;
  localparam int LAL = 4;
  localparam int RAL = 5;

  typedef enum logic [2:0] {
    ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK, ST_LOOKUP
  } state_t;

  state_t         r_state;
  state_t         w_state_n;
  logic [5:0]     r_mods;
  logic [5:0]     w_mods_n;
  logic           w_acc;
  logic           w_ld;
  logic           w_ld_ext;
  logic           w_push;
  logic           w_pop;
  logic           w_full;
  logic           w_wr;
  logic [7:0]     w_ascii;

  logic [7:0]     r_conv_sc;
  logic           r_conv_shift;
  logic           r_conv_ctrl;
  logic           r_conv_alt;
  logic           r_conv_ext;

  logic [7:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic           r_ovf;

`ifdef PS2_CAPSLOCK_EN
  logic           r_caps;
  logic           w_caps_n;
`endif

  assign sc_ready = (r_state != ST_LOOKUP);
  assign w_acc    = sc_valid & sc_ready;

  // state register and modifier/caps state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_mods  <= '0;
`ifdef PS2_CAPSLOCK_EN
      r_caps  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_n;
      r_mods  <= w_mods_n;
`ifdef PS2_CAPSLOCK_EN
      r_caps  <= w_caps_n;
`endif
    end
  end

  // prefix decoding, modifier updates and lookup strobes
  always_comb begin
    w_state_n = r_state;
    w_mods_n  = r_mods;
    w_ld      = 1'b0;
    w_ld_ext  = 1'b0;
    w_push    = 1'b0;
`ifdef PS2_CAPSLOCK_EN
    w_caps_n  = r_caps;
`endif
    unique case (r_state)
      ST_IDLE: if (w_acc) begin
        case (sc_data)
          8'hE0: w_state_n = ST_EXT;
          8'hF0: w_state_n = ST_BRK;
          8'hFA, 8'hE1, 8'hAA: ;
          8'h12: w_mods_n[LSH] = 1'b1;
          8'h59: w_mods_n[RSH] = 1'b1;
          8'h14: w_mods_n[LCT] = 1'b1;
          8'h11: w_mods_n[LAL] = 1'b1;
`ifdef PS2_CAPSLOCK_EN
          8'h58: w_caps_n = ~r_caps;
`endif
          default: begin
            w_ld      = 1'b1;
            w_state_n = ST_LOOKUP;
          end
        endcase
      end
      ST_EXT: if (w_acc) begin
        w_state_n = ST_IDLE;
        case (sc_data)
          8'hF0: w_state_n = ST_EXT_BRK;
          8'h12, 8'h59: ;
          8'h14: w_mods_n[RCT] = 1'b1;
          8'h11: w_mods_n[RAL] = 1'b1;
          default: begin
            w_ld      = 1'b1;
            w_ld_ext  = 1'b1;
            w_state_n = ST_LOOKUP;
          end
        endcase
      end
      ST_BRK: if (w_acc) begin
        w_state_n = ST_IDLE;
        case (sc_data)
          8'h12: w_mods_n[LSH] = 1'b0;
          8'h59: w_mods_n[RSH] = 1'b0;
          8'h14: w_mods_n[LCT] = 1'b0;
          8'h11: w_mods_n[LAL] = 1'b0;
          default: ;
        endcase
      end
      ST_EXT_BRK: if (w_acc) begin
        w_state_n = ST_IDLE;
        case (sc_data)
          8'h14: w_mods_n[RCT] = 1'b0;
          8'h11: w_mods_n[RAL] = 1'b0;
          default: ;
        endcase
      end
      ST_LOOKUP: begin
        w_push    = 1'b1;
        w_state_n = ST_IDLE;
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  // converter control registers, loaded when a key byte is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_conv_sc    <= 8'h00;
      r_conv_shift <= 1'b0;
      r_conv_ctrl  <= 1'b0;
      r_conv_alt   <= 1'b0;
      r_conv_ext   <= 1'b0;
    end else if (w_ld) begin
      r_conv_sc    <= sc_data;
      r_conv_ext   <= w_ld_ext;
      r_conv_shift <= r_mods[LSH] | r_mods[RSH];
      r_conv_ctrl  <= r_mods[LCT] | r_mods[RCT];
      r_conv_alt   <= r_mods[LAL] | r_mods[RAL];
    end
  end

  assign conv_sc     = r_conv_sc;
  assign conv_shift  = r_conv_shift;
  assign conv_ctrl   = r_conv_ctrl;
  assign conv_alt    = r_conv_alt;
  assign conv_extend = r_conv_ext;

  // caps-lock case inversion of the converter result
  always_comb begin
    w_ascii = conv_ascii;
`ifdef PS2_CAPSLOCK_EN
    if (r_caps && !r_conv_shift &&
        conv_ascii >= 8'h61 && conv_ascii <= 8'h7A)
      w_ascii = conv_ascii - 8'h20;
    else if (r_caps && r_conv_shift &&
             conv_ascii >= 8'h41 && conv_ascii <= 8'h5A)
      w_ascii = conv_ascii + 8'h20;
`endif
  end

`ifdef PS2_CAPSLOCK_EN
  assign caps_lock = r_caps;
`else
  assign caps_lock = 1'b0;
`endif

  assign w_pop  = (r_count != '0) & key_ready;
  assign w_full = (r_count == CW'(FIFO_DEPTH));
  assign w_wr   = w_push & (~w_full | w_pop);

  // key FIFO storage, pointers, occupancy and overflow pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 8'h00;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_ovf <= w_push & w_full & ~w_pop;
      if (w_wr) begin
        r_mem[r_wr_ptr] <= w_ascii;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_wr && !w_pop)
        r_count <= r_count + CW'(1);
      else if (!w_wr && w_pop)
        r_count <= r_count - CW'(1);
    end
  end

  assign key_valid = (r_count != '0);
  assign key_ascii = r_mem[r_rd_ptr];
  assign key_count = r_count;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Scoreboard bench for ps2_key_sequencer with a converter stub.
// Caps-lock checks run only when PS2_CAPSLOCK_EN is defined.
module tb_ps2_key_sequencer;

  localparam int D = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sc_valid = 1'b0;
  logic [7:0] sc_data = 8'h00;
  logic       sc_ready;
  logic [7:0] conv_sc;
  logic       conv_shift, conv_ctrl, conv_alt, conv_extend;
  logic [7:0] conv_ascii;
  logic       key_valid;
  logic [7:0] key_ascii;
  logic       key_ready = 1'b1;
  logic [$clog2(D+1)-1:0] key_count;
  logic       overflow;
  logic       caps_lock;

  int n_cmp = 0;
  int n_bad = 0;
  int ovf_cnt = 0;
  logic [7:0] q[$];

  always #5 clk = ~clk;

  ps2_key_sequencer #(.FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .sc_valid(sc_valid), .sc_data(sc_data), .sc_ready(sc_ready),
    .conv_sc(conv_sc), .conv_shift(conv_shift), .conv_ctrl(conv_ctrl),
    .conv_alt(conv_alt), .conv_extend(conv_extend),
    .conv_ascii(conv_ascii),
    .key_valid(key_valid), .key_ascii(key_ascii), .key_ready(key_ready),
    .key_count(key_count), .overflow(overflow), .caps_lock(caps_lock)
  );

  function automatic logic [7:0] stub(input logic [7:0] sc,
                                      input logic sh, input logic ext);
    logic [7:0] r;
    if (ext) return (sc == 8'h75) ? 8'h90 : 8'h00;
    case (sc)
      8'h1C: r = 8'h61;
      8'h32: r = 8'h62;
      8'h21: r = 8'h63;
      8'h23: r = 8'h64;
      8'h24: r = 8'h65;
      8'h2B: r = 8'h66;
      8'h34: r = 8'h67;
      8'h33: r = 8'h68;
      8'h43: r = 8'h69;
      8'h58: r = 8'h80;
      default: r = 8'h3F;
    endcase
    if (sh && r >= 8'h61 && r <= 8'h69) r = r - 8'h20;
    return r;
  endfunction

  assign conv_ascii = stub(conv_sc, conv_shift, conv_extend);

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    while (!sc_ready && t < 10) begin
      @(negedge clk);
      t++;
    end
    if (!sc_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got sc_ready 0 expected 1");
    end
    sc_valid = 1'b1;
    sc_data  = b;
    @(posedge clk);
    #1 sc_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // monitor: compare every popped key against the scoreboard
  always @(negedge clk) begin
    if (!rst && key_valid && key_ready) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL pop_unexpected: got %0h expected none", key_ascii);
      end else begin
        logic [7:0] e;
        e = q.pop_front();
        if (key_ascii !== e) begin
          n_bad++;
          $display("FAIL pop_data: got %0h expected %0h", key_ascii, e);
        end
      end
    end
  end

  always @(negedge clk) if (!rst && overflow) ovf_cnt++;

  initial begin
    // reset values
    idle(2);
    chk("rst_sc_ready", 32'(sc_ready), 1);
    chk("rst_conv_sc", 32'(conv_sc), 0);
    chk("rst_flags", 32'({conv_shift, conv_ctrl, conv_alt, conv_extend}), 0);
    chk("rst_key_valid", 32'(key_valid), 0);
    chk("rst_key_ascii", 32'(key_ascii), 0);
    chk("rst_key_count", 32'(key_count), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_caps", 32'(caps_lock), 0);
    @(negedge clk) rst = 1'b0;
    idle(1);

    // plain make/break with latency
    q.push_back(8'h61);
    send(8'h1C);
    chk("lat_ready_low", 32'(sc_ready), 0);
    chk("lat_valid_n", 32'(key_valid), 0);
    chk("lat_conv_sc", 32'(conv_sc), 32'h1C);
    idle(1);
    chk("lat_valid_n1", 32'(key_valid), 1);
    chk("lat_ascii", 32'(key_ascii), 32'h61);
    send(8'hF0); send(8'h1C);
    idle(4);

    // shift make/break
    send(8'h12);
    q.push_back(8'h41);
    send(8'h1C);
    chk("shift_on", 32'(conv_shift), 1);
    send(8'hF0); send(8'h1C);
    send(8'hF0); send(8'h12);
    q.push_back(8'h61);
    send(8'h1C);
    chk("shift_off", 32'(conv_shift), 0);
    idle(4);

    // extended key
    send(8'hE0);
    q.push_back(8'h90);
    send(8'h75);
    chk("ext_flag", 32'(conv_extend), 1);
    chk("ext_sc", 32'(conv_sc), 32'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    idle(4);

`ifdef PS2_CAPSLOCK_EN
    send(8'h58);
    chk("caps_on", 32'(caps_lock), 1);
    send(8'hF0); send(8'h58);
    q.push_back(8'h41);
    send(8'h1C);
    send(8'h12);
    q.push_back(8'h61);
    send(8'h1C);
    send(8'hF0); send(8'h1C);
    send(8'hF0); send(8'h12);
    send(8'h58);
    chk("caps_off", 32'(caps_lock), 0);
    send(8'hF0); send(8'h58);
`else
    q.push_back(8'h80);
    send(8'h58);
    idle(2);
    chk("caps_tied", 32'(caps_lock), 0);
`endif
    idle(4);

    // overflow: nine makes into an eight-deep FIFO
    key_ready = 1'b0;
    ovf_cnt = 0;
    begin
      logic [7:0] sc [9];
      sc = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
      for (int i = 0; i < 9; i++) begin
        if (i < 8) q.push_back(8'h61 + 8'(i));
        send(sc[i]);
      end
    end
    idle(3);
    chk("ovf_count", 32'(key_count), 8);
    chk("ovf_pulses", 32'(ovf_cnt), 1);
    key_ready = 1'b1;
    idle(12);
    chk("drain_count", 32'(key_count), 0);
    chk("drain_sb", 32'(q.size()), 0);

    // reset mid-sequence
    key_ready = 1'b0;
    send(8'h14);
    send(8'h1C);
    send(8'hE0); send(8'hF0);
    idle(2);
    chk("pre_rst_count", 32'(key_count), 1);
    rst = 1'b1;
    @(negedge clk);
    q.delete();
    @(negedge clk) rst = 1'b0;
    key_ready = 1'b1;
    idle(1);
    chk("mid_rst_ready", 32'(sc_ready), 1);
    chk("mid_rst_count", 32'(key_count), 0);
    chk("mid_rst_ctrl", 32'(conv_ctrl), 0);
    send(8'h14);
    q.push_back(8'h61);
    send(8'h1C);
    chk("post_rst_lctrl", 32'(conv_ctrl), 1);
    idle(6);
    chk("final_sb", 32'(q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_key_sequencer.md
# ps2_key_sequencer

Sequences raw PS/2 scancode bytes from the keyboard receiver into ASCII key events. It tracks prefix bytes (0xE0 extended, 0xF0 break) and modifier state, and drives the combinational scancode-to-ASCII converter through registered control ports. It then buffers the converted codes in a show-ahead FIFO with a valid/ready handshake toward the CPU or terminal logic.

## Interface
- FIFO_DEPTH, 8: key FIFO entries; power of two, ≥2.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- sc_valid  in  1  scancode byte present on sc_data.
- sc_data  in  8  raw scancode byte.
- sc_ready  out  1  byte accepted on an edge where sc_valid & sc_ready.
- conv_sc  out  8  registered scancode to converter.
- conv_shift, conv_ctrl, conv_alt, conv_extend  out  1 each  registered flags to converter.
- conv_ascii  in  8  converter result (combinational from conv_*).
- key_valid  out  1  FIFO not empty.
- key_ascii  out  8  FIFO head (show-ahead).
- key_ready  in  1  consumer pops head on edge where key_valid & key_ready.
- key_count  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy.
- overflow  out  1  one-cycle pulse: converted key dropped, FIFO full.
- caps_lock  out  1  caps-lock toggle state.

## Operation
- States: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (E0 F0), LOOKUP.
- sc_ready = (state != LOOKUP), combinational.
- IDLE: E0→EXT; F0→BRK; FA, E1, AA→dropped, stay IDLE; modifier make→set modifier, stay; other→latch into conv_sc with conv_extend=0, go LOOKUP.
- EXT: F0→EXT_BRK; 12 or 59 (fake shift)→dropped, IDLE; 14→rctrl=1, IDLE; 11→ralt=1, IDLE; other→conv_sc with conv_extend=1, go LOOKUP.
- BRK: 12→lshift=0; 59→rshift=0; 14→lctrl=0; 11→lalt=0; other→ignored; always go to IDLE, no FIFO push.
- EXT_BRK: 14→rctrl=0; 11→ralt=0; other→ignored; always go to IDLE.
- conv_shift = lshift|rshift, conv_ctrl = lctrl|rctrl, conv_alt = lalt|ralt. These are registered at the accepting edge, together with conv_sc.
- LOOKUP: one cycle. Push conv_ascii, after the caps transform, into the FIFO and return to IDLE.
- Typematic repeats of a make code each produce a push.
- Modifier makes and all breaks never push.
- FIFO: push when full and no pop in the same cycle → entry dropped, overflow=1 for one cycle. Push and pop in the same cycle while full → both take effect, count unchanged, no overflow. Pop when empty → ignored.
- Pointers wrap modulo FIFO_DEPTH.
- Reset mid-sequence: state→IDLE, modifiers cleared, FIFO emptied, and any partial prefix is discarded.

## Timing
- Reset values: state IDLE, sc_ready 1, conv_sc 0x00, all conv_* flags 0, key_valid 0, key_ascii 0x00, key_count 0, overflow 0, caps_lock 0, all modifiers 0.
- Make code accepted at edge N: conv_* are valid after N. The FIFO is written at edge N+1. key_valid rises after N+1, giving 2-cycle latency. sc_ready is 0 between edges N and N+1.
- Sustained throughput: one make code per 2 cycles.
- key_ascii updates on the edge after a pop. It is stable while key_valid & !key_ready.

## Configuration
- PS2_CAPSLOCK_EN defined:
  - Make 0x58 in IDLE toggles caps_lock, with no lookup and no push.
  - In LOOKUP, if caps_lock=1 and conv_ascii is 0x61–0x7A with conv_shift=0, push conv_ascii−0x20.
  - If caps_lock=1 and conv_ascii is 0x41–0x5A with conv_shift=1, push conv_ascii+0x20.
  - Otherwise push conv_ascii unchanged.
- PS2_CAPSLOCK_EN undefined:
  - 0x58 is treated as a normal key (lookup and push).
  - caps_lock is tied to 0, and no transform is applied.

## Test plan
- Bytes 1C, F0 1C → one push. Converter stub returns 0x61 → key_ascii=0x61, key_valid 2 edges after acceptance, no second push.
- Bytes 12, 1C, F0 1C, F0 12, 1C → conv_shift=1 on the first lookup and 0 on the second. Pushes are 0x41 then 0x61.
- Bytes E0 75, E0 F0 75 → conv_extend=1, conv_sc=0x75. One push of 0x90.
- With PS2_CAPSLOCK_EN: 58, F0 58, 1C → caps_lock=1, push 0x41. Then 12, 1C → push 0x61.
- FIFO_DEPTH=8, key_ready=0, 9 makes → count=8, overflow pulses once on the 9th push. Then key_ready=1 → 8 entries drain in order.
- Assert rst after E0 F0 while lctrl=1 → after release, state IDLE, modifiers 0, key_count=0. The next byte 14 is treated as left-ctrl make.
